// File: rtl/muldiv_pkg.sv
// Shared constants for the sequential RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and the step counter width.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_PREP = ST_PREP,
    S_CALC = ST_CALC,
    S_FIX  = ST_FIX,
    S_DONE = ST_DONE
  } state_e;

  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate; 64 bits by default, narrowed to
// operand width where only the low word matters.
module muldiv_negate #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide: operands are reduced to magnitudes, run
// through a one-bit-per-cycle shift-add / restoring-divide core, then sign-fixed.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e              r_state;
  logic [2:0]          r_f3;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic [XLEN-1:0]     r_mag_a;
  logic [XLEN-1:0]     r_mag_b;
  logic                r_sign_a;
  logic                r_sign_b;
  logic [2*XLEN-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [XLEN-1:0]     r_result;

  logic                w_is_div;
  logic                w_neg_a_req;
  logic                w_neg_b_req;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [XLEN:0]       w_div_shift;
  logic                w_q_bit;
  logic [XLEN-1:0]     w_div_rem;
  logic [2*XLEN-1:0]   w_div_next;
  logic [2*XLEN-1:0]   w_fix_in;
  logic                w_fix_neg;
  logic [2*XLEN-1:0]   w_fix_out;
  logic [XLEN-1:0]     w_fix_result;

  assign w_is_div    = r_f3[2];
  assign w_neg_a_req = a_is_signed(r_f3) & r_a[XLEN-1];
  assign w_neg_b_req = b_is_signed(r_f3) & r_b[XLEN-1];

  muldiv_negate #(.W(XLEN)) u_neg_a (
    .i_val (r_a),
    .i_neg (w_neg_a_req),
    .o_val (w_abs_a)
  );

  muldiv_negate #(.W(XLEN)) u_neg_b (
    .i_val (r_b),
    .i_neg (w_neg_b_req),
    .o_val (w_abs_b)
  );

  // Multiply: acc = {partial_hi, multiplier_lo}; add multiplicand on LSB, shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at the LSB.
  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_q_bit     = (w_div_shift >= {1'b0, r_mag_b});
  assign w_div_rem   = w_q_bit ? (w_div_shift[XLEN-1:0] - r_mag_b) : w_div_shift[XLEN-1:0];
  assign w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_q_bit};

  always_comb begin
    w_fix_in  = r_acc;
    w_fix_neg = r_sign_a ^ r_sign_b;
    case (r_f3)
      F3_DIV, F3_DIVU: w_fix_in = {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
      F3_REM, F3_REMU: begin
        w_fix_in  = {{XLEN{1'b0}}, r_acc[2*XLEN-1:XLEN]};
        w_fix_neg = r_sign_a;
      end
      default: ;
    endcase
  end

  muldiv_negate #(.W(2*XLEN)) u_neg_fix (
    .i_val (w_fix_in),
    .i_neg (w_fix_neg),
    .o_val (w_fix_out)
  );

  assign w_fix_result = ((r_f3 == F3_MULH) || (r_f3 == F3_MULHSU) || (r_f3 == F3_MULHU))
                      ? w_fix_out[2*XLEN-1:XLEN] : w_fix_out[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_f3     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (flush && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_f3    <= funct3;
            r_a     <= op_a;
            r_b     <= op_b;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_sign_a <= w_neg_a_req;
          r_sign_b <= w_neg_b_req;
          r_mag_a  <= w_abs_a;
          r_mag_b  <= w_abs_b;
          r_cnt    <= '1;
          r_acc    <= w_is_div ? {{XLEN{1'b0}}, w_abs_a} : {{XLEN{1'b0}}, w_abs_b};
          // Divide by zero bypasses the core: all-ones quotient, dividend as remainder.
          if (w_is_div && (r_b == '0)) begin
            r_result <= r_f3[1] ? r_a : '1;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= w_is_div ? w_div_next : w_mul_next;
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          r_result <= w_fix_result;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed ops push expected result and done
// cycle; a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
    int          exp_cyc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  logic [31:0] last_result = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: result %h at cycle %0d, expected no done", result, cyc);
      end else begin
        e = sb_q.pop_front();
        check(e.name, result, e.exp);
        check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.exp_cyc));
      end
    end else if ((sb_q.size() != 0) && (cyc > sb_q[0].exp_cyc)) begin
      e = sb_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no done by cycle %0d, expected done at cycle %0d", e.name, cyc, e.exp_cyc);
    end
  end

  // Called at a negedge (cycle 0 of the op); returns at the negedge of cycle 1.
  task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input bit push, input logic [31:0] exp, input int lat);
    if (push) begin
      sb_q.push_back('{name, exp, cyc + lat});
      last_result = exp;
    end
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic run(input vec_t v);
    issue(v.name, v.f3, v.a, v.b, 1'b1, v.exp, v.lat);
    repeat (v.lat) @(negedge clk);
  endtask

  initial begin
    int bad;
    vecs.push_back('{"mulh_min_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35});
    vecs.push_back('{"mulhu_max_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35});
    vecs.push_back('{"mulhsu_m1_max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35});
    vecs.push_back('{"mulh_m1_m1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35});
    vecs.push_back('{"mul_shift",       3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 35});
    vecs.push_back('{"div_m7_2",        3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 35});
    vecs.push_back('{"rem_m7_2",        3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 35});
    vecs.push_back('{"divu_7_2",        3'b101, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 35});
    vecs.push_back('{"remu_7_2",        3'b111, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 35});
    vecs.push_back('{"div_7_m2",        3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35});
    vecs.push_back('{"rem_7_m2",        3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 35});
    vecs.push_back('{"divu_max_1",      3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 35});
    vecs.push_back('{"div_overflow",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35});
    vecs.push_back('{"rem_overflow",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 35});
    vecs.push_back('{"div_5_by_0",      3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2});
    vecs.push_back('{"remu_5_by_0",     3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 2});

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First op: busy window and starts that must be ignored (mid-op and in DONE).
    check("mul_busy_cycle0", {31'b0, busy}, 32'd0);
    issue("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 35);
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy !== (k <= 35)) bad++;
      start  = (k == 5) || (k == 35);
      funct3 = 3'b011;
      op_a   = 32'hDEAD_BEEF;
      op_b   = 32'h0000_0003;
      @(negedge clk);
    end
    start = 1'b0;
    check("mul_busy_window_errors", 32'(bad), 32'd0);
    repeat (40) @(negedge clk);

    foreach (vecs[i]) run(vecs[i]);

    // Flush a divide in cycle 10: busy drops in cycle 11, result keeps its value.
    issue("div_flushed", 3'b100, 32'd100, 32'd3, 1'b0, 32'd0, 35);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_result_held", result, last_result);
    run('{"mul_3_4_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 35});
    check("result_held_idle", result, 32'd12);

    // Asynchronous reset in cycle 20 of a multiply.
    issue("mul_reset", 3'b000, 32'd5, 32'd6, 1'b0, 32'd0, 35);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", {31'b0, busy}, 32'd0);
    check("async_reset_done", {31'b0, done}, 32'd0);
    check("async_reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run('{"divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 35});

    repeat (5) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
